simd_exec_pipe: RTL and testbench
=================================

Name: simd_exec_pipe

Overview:
- Parametrised, pipelined successor to the SIMD execute stage.
- Applies one element-wise op across PE_COUNT lanes and reduces the lane results into a wide signed sum, either per beat or accumulated over a multi-beat vector.
- Adds a valid/ready handshake with full-pipeline backpressure, optional signed saturation, and a wide accumulator.
- Sits between operand fetch (upstream) and writeback (downstream).

Parameters:
- PE_COUNT, 4: lane count; power of two, at least 2.
- DATA_WIDTH, 32: lane width in bits; lanes are signed two's complement.
- ACC_WIDTH, 40: width of the reduction and accumulator; must be at least DATA_WIDTH+log2(PE_COUNT).
- SATURATE, 0: 1 = ADD/SUB/MUL saturate to signed DATA_WIDTH range; 0 = wrap.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- in_a  in  [PE_COUNT-1:0][DATA_WIDTH-1:0]  operand A lanes.
- in_b  in  [PE_COUNT-1:0][DATA_WIDTH-1:0]  operand B lanes.
- in_op  in  3  lane op: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR, 6 MAX, 7 MIN.
- in_mode  in  2  0 ELEM, 1 DOT, 2 DOT_ACC, 3 reserved (treated as ELEM).
- in_last  in  1  final beat of a DOT_ACC sequence; ignored in other modes.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- elem_out  out  [PE_COUNT-1:0][DATA_WIDTH-1:0]  per-lane results.
- dot_out  out  ACC_WIDTH  reduction or accumulated result.
- acc_active  out  1  a DOT_ACC sequence is open.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is synchronous and active-high.
  - On reset: out_valid=0, elem_out=0, dot_out=0, accumulator=0, acc_active=0, all stage valids=0.
  - in_ready=0 while rst is high.
  - Reset mid-sequence discards the partial accumulation with no output.
- Handshake:
  - Transfer occurs when in_valid && in_ready.
  - advance = !out_valid || out_ready.
  - in_ready = advance && !rst.
  - When !advance, every stage holds; elem_out and dot_out stay stable while out_valid=1.
- Pipeline (latency 2 cycles from accepted beat to out_valid):
  - S1 registers the lane results plus mode, last and valid.
  - S2 registers the outputs, the reduction and the accumulator.
  - Idle cycles (in_valid=0) travel as bubbles.
  - Sustained throughput is 1 beat/cycle while out_ready=1.
- Lane arithmetic:
  - ADD/SUB/MUL are signed. MUL takes the low DATA_WIDTH bits of the product.
  - With SATURATE=1, ADD/SUB/MUL clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - AND/OR/XOR are bitwise.
  - MAX/MIN are signed compares.
- Reduction:
  - sum = signed sum of the sign-extended lane results, at ACC_WIDTH.
  - Reduction and accumulation wrap at ACC_WIDTH and never saturate.
- Modes at S2 advance:
  - ELEM: out_valid=1; elem_out = lane results; dot_out = 0.
  - DOT: out_valid=1; elem_out = lane results; dot_out = sum.
  - DOT_ACC with last=0: accumulator += sum; acc_active=1; no output, so out_valid goes to 0 if the previous output was consumed.
  - DOT_ACC with last=1: out_valid=1; dot_out = accumulator+sum; elem_out = lane results of this beat; accumulator=0; acc_active=0.
  - A single-beat DOT_ACC with last=1 behaves like DOT.
- Interleaving:
  - ELEM or DOT beats inside an open DOT_ACC sequence execute normally.
  - They leave the accumulator and acc_active untouched.
- Ordering:
  - Results leave in acceptance order.
  - Under any out_ready pattern, no result is lost or duplicated.

Test Plan:
1. ELEM ADD, in_a={1,2,3,4}, in_b={10,20,30,40}, out_ready=1 -> two cycles later out_valid=1 for 1 cycle, elem_out={11,22,33,44}, dot_out=0.
2. DOT MUL, in_a={1,2,3,4}, in_b={5,6,7,8} -> dot_out=70. Same with in_a={-1,-2,-3,-4} -> dot_out=-70 (0xFFFFFFFFBA at 40 bits).
3. Three DOT_ACC MUL beats of test 2, in_last only on the third -> exactly one output with dot_out=210. acc_active is 1 after beat 1 and 0 after beat 3. A DOT ADD beat inserted mid-sequence outputs its own sum, and the sequence still yields 210.
4. Stream 4 ELEM beats with out_ready=0 -> in_ready falls and the first result holds stable. Set out_ready=1 -> all 4 results arrive in order, once each.
5. ADD 0x7FFFFFFF+1 -> SATURATE=1 gives 0x7FFFFFFF; SATURATE=0 gives 0x80000000. DOT ADD with in_a lanes all 0x7FFFFFFF and in_b=0 -> dot_out=0x01FFFFFFFC, no overflow.
6. Two non-last DOT_ACC beats, then rst for 1 cycle -> acc_active=0, out_valid=0. Then DOT_ACC MUL {1,1,1,1}x{1,1,1,1} with last=1 -> dot_out=4.

Source files
------------

// File: rtl/simd_exec_pipe.sv
// PE_COUNT-lane SIMD execute with reduction/accumulate; 2-cycle latency, 1 beat/cycle.
// Backpressure: any stalled output (out_valid && !out_ready) freezes every stage.
module simd_exec_pipe #(
   parameter int PE_COUNT   = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ACC_WIDTH  = 40,
   parameter int SATURATE   = 0
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [PE_COUNT-1:0][DATA_WIDTH-1:0]  in_a,
   input  logic [PE_COUNT-1:0][DATA_WIDTH-1:0]  in_b,
   input  logic [2:0]                           in_op,
   input  logic [1:0]                           in_mode,
   input  logic                                 in_last,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [PE_COUNT-1:0][DATA_WIDTH-1:0]  elem_out,
   output logic [ACC_WIDTH-1:0]                 dot_out,
   output logic                                 acc_active
);
   localparam logic [1:0] MODE_ELEM = 2'd0;
   localparam logic [1:0] MODE_DOT  = 2'd1;
   localparam logic [1:0] MODE_ACC  = 2'd2;
   localparam logic [DATA_WIDTH-1:0] MAXV = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] MINV = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic                                 w_advance;
   logic [PE_COUNT-1:0][DATA_WIDTH-1:0]  w_lane;
   logic [ACC_WIDTH-1:0]                 w_sum;

   logic                                 r_s1_vld;
   logic [PE_COUNT-1:0][DATA_WIDTH-1:0]  r_s1_lane;
   logic [1:0]                           r_s1_mode;
   logic                                 r_s1_last;

   logic                                 r_out_vld;
   logic [PE_COUNT-1:0][DATA_WIDTH-1:0]  r_elem;
   logic [ACC_WIDTH-1:0]                 r_dot;
   logic [ACC_WIDTH-1:0]                 r_acc;
   logic                                 r_acc_active;

   assign w_advance  = !r_out_vld || out_ready;
   assign in_ready   = w_advance && !rst;
   assign out_valid  = r_out_vld;
   assign elem_out   = r_elem;
   assign dot_out    = r_dot;
   assign acc_active = r_acc_active;

   for (genvar g = 0; g < PE_COUNT; g++) begin : g_lane
      logic signed [DATA_WIDTH-1:0]   w_a, w_b;
      logic        [DATA_WIDTH:0]     w_add, w_sub;
      logic        [2*DATA_WIDTH-1:0] w_mul;
      logic                           w_add_ovf, w_sub_ovf, w_mul_ovf;
      logic        [DATA_WIDTH-1:0]   w_add_r, w_sub_r, w_mul_r, w_res;

      assign w_a   = in_a[g];
      assign w_b   = in_b[g];
      assign w_add = {w_a[DATA_WIDTH-1], w_a} + {w_b[DATA_WIDTH-1], w_b};
      assign w_sub = {w_a[DATA_WIDTH-1], w_a} - {w_b[DATA_WIDTH-1], w_b};
      assign w_mul = {{DATA_WIDTH{w_a[DATA_WIDTH-1]}}, w_a} * {{DATA_WIDTH{w_b[DATA_WIDTH-1]}}, w_b};

      // Overflow when the bits above the signed result are not a pure sign extension.
      assign w_add_ovf = w_add[DATA_WIDTH] != w_add[DATA_WIDTH-1];
      assign w_sub_ovf = w_sub[DATA_WIDTH] != w_sub[DATA_WIDTH-1];
      assign w_mul_ovf = !(&w_mul[2*DATA_WIDTH-1:DATA_WIDTH-1]) && (|w_mul[2*DATA_WIDTH-1:DATA_WIDTH-1]);

      assign w_add_r = (SATURATE != 0 && w_add_ovf) ? (w_add[DATA_WIDTH] ? MINV : MAXV)
                                                     : w_add[DATA_WIDTH-1:0];
      assign w_sub_r = (SATURATE != 0 && w_sub_ovf) ? (w_sub[DATA_WIDTH] ? MINV : MAXV)
                                                     : w_sub[DATA_WIDTH-1:0];
      assign w_mul_r = (SATURATE != 0 && w_mul_ovf) ? (w_mul[2*DATA_WIDTH-1] ? MINV : MAXV)
                                                     : w_mul[DATA_WIDTH-1:0];

      always_comb begin
         w_res = '0;
         case (in_op)
            3'd0:    w_res = w_add_r;
            3'd1:    w_res = w_sub_r;
            3'd2:    w_res = w_mul_r;
            3'd3:    w_res = w_a & w_b;
            3'd4:    w_res = w_a | w_b;
            3'd5:    w_res = w_a ^ w_b;
            3'd6:    w_res = (w_a > w_b) ? w_a : w_b;
            default: w_res = (w_a < w_b) ? w_a : w_b;
         endcase
      end

      assign w_lane[g] = w_res;
   end

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < PE_COUNT; i++) begin
         w_sum = w_sum + {{(ACC_WIDTH-DATA_WIDTH){r_s1_lane[i][DATA_WIDTH-1]}}, r_s1_lane[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_vld  <= 1'b0;
         r_s1_lane <= '0;
         r_s1_mode <= MODE_ELEM;
         r_s1_last <= 1'b0;
      end else if (w_advance) begin
         r_s1_vld  <= in_valid;
         r_s1_lane <= w_lane;
         r_s1_mode <= (in_mode == 2'd3) ? MODE_ELEM : in_mode;
         r_s1_last <= in_last;
      end
   end

   // Non-last DOT_ACC beats only update the accumulator and leave the outputs as they were.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_vld    <= 1'b0;
         r_elem       <= '0;
         r_dot        <= '0;
         r_acc        <= '0;
         r_acc_active <= 1'b0;
      end else if (w_advance) begin
         r_out_vld <= 1'b0;
         if (r_s1_vld) begin
            case (r_s1_mode)
               MODE_DOT: begin
                  r_out_vld <= 1'b1;
                  r_elem    <= r_s1_lane;
                  r_dot     <= w_sum;
               end
               MODE_ACC: begin
                  if (r_s1_last) begin
                     r_out_vld    <= 1'b1;
                     r_elem       <= r_s1_lane;
                     r_dot        <= r_acc + w_sum;
                     r_acc        <= '0;
                     r_acc_active <= 1'b0;
                  end else begin
                     r_acc        <= r_acc + w_sum;
                     r_acc_active <= 1'b1;
                  end
               end
               default: begin
                  r_out_vld <= 1'b1;
                  r_elem    <= r_s1_lane;
                  r_dot     <= '0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_simd_exec_pipe.sv
// Bench for simd_exec_pipe: wrapping and saturating instances share one stimulus stream.
module tb_simd_exec_pipe;
   localparam int PE = 4;
   localparam int DW = 32;
   localparam int AW = 40;
   localparam int EW = PE * DW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   rst, in_valid, in_last, out_ready;
   logic [PE-1:0][DW-1:0]  in_a, in_b;
   logic [2:0]             in_op;
   logic [1:0]             in_mode;
   logic                   rdy0, rdy1, ov0, ov1, aa0, aa1;
   logic [PE-1:0][DW-1:0]  e0, e1;
   logic [AW-1:0]          d0, d1;

   simd_exec_pipe #(.PE_COUNT(PE), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .SATURATE(0)) u_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_a(in_a), .in_b(in_b),
      .in_op(in_op), .in_mode(in_mode), .in_last(in_last), .out_valid(ov0), .out_ready(out_ready),
      .elem_out(e0), .dot_out(d0), .acc_active(aa0));

   simd_exec_pipe #(.PE_COUNT(PE), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .SATURATE(1)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_a(in_a), .in_b(in_b),
      .in_op(in_op), .in_mode(in_mode), .in_last(in_last), .out_valid(ov1), .out_ready(out_ready),
      .elem_out(e1), .dot_out(d1), .acc_active(aa1));

   typedef struct {
      logic [EW-1:0] elem;
      logic [AW-1:0] dot;
   } exp_t;

   exp_t   q0[$];
   exp_t   q1[$];
   longint acc_m[2];
   int     tests = 0;
   int     fails = 0;
   bit     accepted;
   bit     rand_rdy;

   task automatic chk_v(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic logic [PE-1:0][DW-1:0] vec(input logic [DW-1:0] x0, x1, x2, x3);
      vec = {x3, x2, x1, x0};
   endfunction

   // Reference lane result as a mathematical signed value.
   function automatic longint lane_ref(input int op, input longint a, input longint b, input bit sat);
      longint r;
      logic [63:0] bits;
      case (op)
         0: r = a + b;
         1: r = a - b;
         2: r = a * b;
         3: return a & b;
         4: return a | b;
         5: return a ^ b;
         6: return (a > b) ? a : b;
         default: return (a < b) ? a : b;
      endcase
      if (sat) begin
         if (r > 64'sd2147483647)  r = 64'sd2147483647;
         if (r < -64'sd2147483648) r = -64'sd2147483648;
      end else begin
         bits = r;
         r = longint'($signed(bits[31:0]));
      end
      return r;
   endfunction

   task automatic model_accept();
      for (int s = 0; s < 2; s++) begin
         exp_t        e;
         longint      sum = 0;
         longint      v, tot;
         logic [63:0] vb, sb;
         int          mode = (in_mode == 2'd3) ? 0 : int'(in_mode);
         for (int i = 0; i < PE; i++) begin
            v  = lane_ref(int'(in_op), longint'($signed(in_a[i])), longint'($signed(in_b[i])), s == 1);
            vb = v;
            e.elem[i*DW +: DW] = vb[31:0];
            sum += v;
         end
         tot = (mode == 2) ? acc_m[s] + sum : sum;
         sb  = tot;
         e.dot = (mode == 0) ? '0 : sb[AW-1:0];
         if (mode == 2 && !in_last) begin
            acc_m[s] = tot;
         end else begin
            if (mode == 2) acc_m[s] = 0;
            if (s == 0) q0.push_back(e);
            else        q1.push_back(e);
         end
      end
   endtask

   task automatic cmp(input int s, input logic ov, input logic [EW-1:0] eo, input logic [AW-1:0] dout);
      exp_t f;
      bit   have;
      if (!ov) return;
      have = (s == 0) ? (q0.size() > 0) : (q1.size() > 0);
      chk_b($sformatf("out_expected_s%0d", s), have, 1'b1);
      if (!have) return;
      f = (s == 0) ? q0[0] : q1[0];
      chk_v($sformatf("elem_s%0d%s", s, out_ready ? "" : "_hold"), eo, f.elem);
      chk_v($sformatf("dot_s%0d%s", s, out_ready ? "" : "_hold"), EW'(dout), EW'(f.dot));
      if (out_ready) begin
         if (s == 0) void'(q0.pop_front());
         else        void'(q1.pop_front());
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cmp(0, ov0, e0, d0);
      cmp(1, ov1, e1, d1);
      accepted = in_valid && rdy0;
      if (accepted) model_accept();
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input logic [PE-1:0][DW-1:0] a, input logic [PE-1:0][DW-1:0] b,
                       input logic [2:0] op, input logic [1:0] mode, input logic last);
      in_a = a; in_b = b; in_op = op; in_mode = mode; in_last = last; in_valid = 1'b1;
      accepted = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (accepted) break;
      end
      chk_b("send_accepted", accepted, 1'b1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      in_valid = 1'b0;
      rand_rdy = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 200 && (q0.size() > 0 || q1.size() > 0); i++) tick();
      repeat (3) tick();
      chk_v("drain_q0_empty", EW'(q0.size()), '0);
      chk_v("drain_q1_empty", EW'(q1.size()), '0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      #1;
      chk_b("rst_in_ready", rdy0, 1'b0);
      chk_b("rst_in_ready_sat", rdy1, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      q0.delete(); q1.delete();
      acc_m[0] = 0; acc_m[1] = 0;
      chk_b("rst_out_valid", ov0, 1'b0);
      chk_b("rst_acc_active", aa0, 1'b0);
      chk_b("rst_acc_active_sat", aa1, 1'b0);
   endtask

   function automatic logic [DW-1:0] rnd_lane();
      logic [DW-1:0] x;
      case ($urandom_range(0, 3))
         0: x = $urandom;
         1: begin x = $urandom_range(0, 20); x = x - 32'd10; end
         2: x = 32'h7FFFFFFF - $urandom_range(0, 3);
         default: x = 32'h80000000 + $urandom_range(0, 3);
      endcase
      return x;
   endfunction

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1; rand_rdy = 1'b0;
      in_a = '0; in_b = '0; in_op = '0; in_mode = '0;
      acc_m[0] = 0; acc_m[1] = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_b("reset_in_ready", rdy0, 1'b0);
      rst = 1'b0;
      chk_b("reset_out_valid", ov0, 1'b0);
      chk_v("reset_elem", e0, '0);
      chk_v("reset_dot", EW'(d0), '0);
      chk_b("reset_acc_active", aa0, 1'b0);
      #1;
      chk_b("post_reset_in_ready", rdy0, 1'b1);

      // ELEM ADD latency and single-cycle valid
      send(vec(1, 2, 3, 4), vec(10, 20, 30, 40), 3'd0, 2'd0, 1'b0);
      chk_b("t1_not_yet", ov0, 1'b0);
      tick();
      chk_b("t1_valid", ov0, 1'b1);
      chk_v("t1_elem", e0, vec(11, 22, 33, 44));
      chk_v("t1_dot", EW'(d0), '0);
      tick();
      chk_b("t1_one_cycle", ov0, 1'b0);

      // DOT MUL positive and negative
      send(vec(1, 2, 3, 4), vec(5, 6, 7, 8), 3'd2, 2'd1, 1'b0);
      send(vec(-1, -2, -3, -4), vec(5, 6, 7, 8), 3'd2, 2'd1, 1'b0);
      chk_v("t2_dot_pos", EW'(d0), EW'(40'd70));
      tick();
      chk_v("t2_dot_neg", EW'(d0), EW'(40'hFFFFFFFFBA));
      drain();

      // DOT_ACC sequence with an interleaved DOT ADD
      send(vec(1, 2, 3, 4), vec(5, 6, 7, 8), 3'd2, 2'd2, 1'b0);
      send(vec(1, 2, 3, 4), vec(5, 6, 7, 8), 3'd2, 2'd2, 1'b0);
      chk_b("t3_acc_active", aa0, 1'b1);
      send(vec(1, 2, 3, 4), vec(5, 6, 7, 8), 3'd0, 2'd1, 1'b0);
      send(vec(1, 2, 3, 4), vec(5, 6, 7, 8), 3'd2, 2'd2, 1'b1);
      chk_v("t3_mid_dot", EW'(d0), EW'(40'd36));
      tick();
      chk_b("t3_final_valid", ov0, 1'b1);
      chk_v("t3_final_dot", EW'(d0), EW'(40'd210));
      chk_b("t3_acc_closed", aa0, 1'b0);
      drain();

      // Backpressure: stall with out_ready low, then release
      out_ready = 1'b0;
      send(vec(1, 1, 1, 1), vec(100, 100, 100, 100), 3'd0, 2'd0, 1'b0);
      send(vec(2, 2, 2, 2), vec(100, 100, 100, 100), 3'd0, 2'd0, 1'b0);
      in_a = vec(3, 3, 3, 3); in_b = vec(100, 100, 100, 100); in_op = 3'd0; in_mode = 2'd0;
      in_valid = 1'b1;
      repeat (3) begin
         tick();
         chk_b("t4_in_ready_low", rdy0, 1'b0);
         chk_v("t4_hold_elem", e0, vec(101, 101, 101, 101));
      end
      out_ready = 1'b1;
      send(vec(3, 3, 3, 3), vec(100, 100, 100, 100), 3'd0, 2'd0, 1'b0);
      send(vec(4, 4, 4, 4), vec(100, 100, 100, 100), 3'd0, 2'd0, 1'b0);
      drain();

      // Saturation vs wrap, wide reduction without overflow
      send(vec(32'h7FFFFFFF, 0, 0, 0), vec(1, 0, 0, 0), 3'd0, 2'd0, 1'b0);
      send(vec(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF), vec(0, 0, 0, 0), 3'd0, 2'd1, 1'b0);
      chk_v("t5_wrap", EW'(e0[0]), EW'(32'h80000000));
      chk_v("t5_sat", EW'(e1[0]), EW'(32'h7FFFFFFF));
      tick();
      chk_v("t5_wide_dot", EW'(d0), EW'(40'h01FFFFFFFC));
      chk_v("t5_wide_dot_sat", EW'(d1), EW'(40'h01FFFFFFFC));
      drain();

      // Reset in the middle of an open DOT_ACC sequence
      send(vec(1, 2, 3, 4), vec(5, 6, 7, 8), 3'd2, 2'd2, 1'b0);
      send(vec(1, 2, 3, 4), vec(5, 6, 7, 8), 3'd2, 2'd2, 1'b0);
      tick();
      chk_b("t6_open", aa0, 1'b1);
      do_reset();
      send(vec(1, 1, 1, 1), vec(1, 1, 1, 1), 3'd2, 2'd2, 1'b1);
      tick();
      chk_b("t6_valid", ov0, 1'b1);
      chk_v("t6_dot", EW'(d0), EW'(40'd4));
      drain();

      // Randomised traffic with random downstream readiness
      rand_rdy = 1'b1;
      for (int n = 0; n < 300; n++) begin
         logic [PE-1:0][DW-1:0] ra, rb;
         for (int i = 0; i < PE; i++) begin
            ra[i] = rnd_lane();
            rb[i] = rnd_lane();
         end
         send(ra, rb, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
